hs_responder: RTL and testbench
===============================

# hs_responder

Responder end of the req/ack/done handshake that our procedural `expect` checks exercise. Once armed by `start`, it answers each sampled `req` with a single-cycle `ack` after a programmable latency of MIN_LAT..MAX_LAT cycles, then a single-cycle `done` one cycle later. It returns the captured request data on `data`. It sits beside the initiator in handshake test harnesses, so that `req ##[1:5] ack`, `req ##1 ack ##1 done` and `req |-> ##[1:10] (ack && !done)` hold on real RTL.

## Interface
- MIN_LAT, 1: minimum req-to-ack latency in cycles; must be ≥1.
- MAX_LAT, 5: maximum req-to-ack latency; must be ≥ MIN_LAT and ≤ 7.
- DATA_W, 8: width of the request and response data.
- clk  in  1  the single clock; all logic is on its rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  in  1  arm request; the block is armed from the first cycle start=1 is sampled.
- req  in  1  request strobe, sampled each cycle.
- lat_cfg  in  3  requested latency, captured together with req.
- req_data  in  DATA_W  request payload, captured together with req.
- ack  out  1  one-cycle acknowledge pulse.
- done  out  1  one-cycle completion pulse, always exactly one cycle after ack.
- data  out  DATA_W  payload of the acknowledged request; valid in the ack cycle and held until the next ack.
- busy  out  1  high from the capture cycle through the done cycle.
- ovf  out  1  sticky: a request was dropped. Cleared only by reset.
- txn_cnt  out  16  count of completed transactions; increments on done and wraps at 2^16.

## Operation
- States (enum): IDLE, READY, WAIT, ACK, DONE.
- IDLE: wait for start=1, then go to READY. req is ignored in IDLE; this is not an error.
- After arming, the block stays armed until reset. start is don't-care from then on.
- READY, req=1: capture req_data and the effective latency L, then go to WAIT. If L=1, go straight to ACK.
- Effective latency L: lat_cfg clamped to [MIN_LAT, MAX_LAT]. lat_cfg=0 gives MIN_LAT; lat_cfg>MAX_LAT gives MAX_LAT.
- WAIT: count down, and go to ACK so that ack asserts exactly L cycles after the capture cycle.
- ACK: ack=1, and data is updated in this same cycle. Next state is DONE.
- DONE: done=1, txn_cnt increments. Next state:
  - if the pending slot is full, go to WAIT (or to ACK if its L=1) and count from this cycle;
  - otherwise go to READY.
- Pending slot: one entry holding data and L.
  - req=1 in WAIT, ACK or DONE with the slot empty: store the request in the slot.
  - req=1 with the slot full: drop the request and set ovf.
  - The slot is consumed at DONE, as above.
- ack and done are never high in the same cycle.
- busy=1 in every state except IDLE and READY.

## Timing
- Reset values: all outputs are 0, state is IDLE, the pending slot is empty, and the block is disarmed.
- Reset asserted mid-transaction aborts it. No ack or done is issued in the cycle after reset.
- Latency, single request: req sampled at cycle t gives ack at t+L and done at t+L+1.
- Pending request: ack at the previous done cycle + L, so `done ##L ack`.
- Minimum spacing between acks is L+1 cycles.
- Simultaneous events:
  - req in the DONE cycle with an empty slot is stored, then consumed in that same cycle's transition.
  - Arming and req in the same cycle: req is ignored, because the block is only armed from the next cycle.

## Structure
- Package `hs_pkg` holds:
  - the state enum `hs_state_e`;
  - the LAT_W=3 constant;
  - the function `hs_clamp_lat(lat, min, max)`.
- Sub-module `hs_lat_counter`:
  - loadable down-counter with `load`, `lat`, `expire` and `busy`;
  - `expire` pulses on the cycle that must drive ack.
- The top level holds the FSM, the pending slot, the data register, ovf and txn_cnt.

## Test plan
- Reset then start=1: req=1 at cycle 10 with lat_cfg=3 and req_data=8'hA5 gives ack at 13 with data=A5, done at 14, and txn_cnt=1.
- lat_cfg=0, then lat_cfg=7, with defaults: ack at t+1, then ack at t+5. `req |=> ack` holds for the first; ack and done are never coincident.
- Before start: req=1 in IDLE gives no ack, ovf=0 and busy=0.
- Back-to-back: req at 10 (L=2) and at 11 (L=1) gives ack at 12, done at 13, ack at 14, done at 15.
- Overflow: req at 10, 11 and 12, all L=5. The third request is dropped, ovf=1 from cycle 13, and only two acks occur.
- Reset mid-transaction: req at 10 with L=4, rst_n=0 at 12. The outputs are 0, and no ack appears at 14.
- Wrap: preload about 65535 transactions, or force txn_cnt; one more done wraps it to 0.

Source files
------------

// File: rtl/hs_pkg.sv
// hs_pkg: shared types and helpers for the req/ack/done responder.
package hs_pkg;
    localparam int LAT_W = 3;

    typedef enum logic [2:0] {IDLE, READY, WAIT, ACK, DONE} hs_state_e;

    function automatic logic [LAT_W-1:0] hs_clamp_lat(input logic [LAT_W-1:0] lat,
                                                      input logic [LAT_W-1:0] min_lat,
                                                      input logic [LAT_W-1:0] max_lat);
        return (lat < min_lat) ? min_lat : ((lat > max_lat) ? max_lat : lat);
    endfunction
endpackage

// File: rtl/hs_lat_counter.sv
// hs_lat_counter: loadable down-counter; expire marks the cycle whose edge must enter ACK.
module hs_lat_counter
    import hs_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [LAT_W-1:0] lat,
    output logic             expire,
    output logic             busy
);
    logic [LAT_W-1:0] cnt_q, cnt_d;

    // Loading L-1 makes the count reach 1 exactly one edge before ack must show.
    always_comb begin
        cnt_d = load ? lat - LAT_W'(1) : ((cnt_q != '0) ? cnt_q - LAT_W'(1) : '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expire = (cnt_q == LAT_W'(1));
    assign busy   = (cnt_q != '0);
endmodule

// File: rtl/hs_responder.sv
// hs_responder: responder side of the req/ack/done handshake with a one-entry pending slot.
module hs_responder
    import hs_pkg::*;
#(
    parameter int MIN_LAT = 1,
    parameter int MAX_LAT = 5,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              req,
    input  logic [LAT_W-1:0]  lat_cfg,
    input  logic [DATA_W-1:0] req_data,
    output logic              ack,
    output logic              done,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              ovf,
    output logic [15:0]       txn_cnt
);
    hs_state_e         state_q, state_d;
    logic [DATA_W-1:0] cur_data_q, cur_data_d, slot_data_q, slot_data_d, data_q, data_d;
    logic [LAT_W-1:0]  slot_lat_q, slot_lat_d, req_lat, cap_lat;
    logic [DATA_W-1:0] cap_data;
    logic              slot_full_q, slot_full_d, ack_q, ack_d, done_q, done_d;
    logic              busy_q, busy_d, ovf_q, ovf_d;
    logic [15:0]       txn_cnt_q, txn_cnt_d;
    logic              take_slot, cap, store, in_flight, expire, cnt_busy;

    hs_lat_counter u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (cap),
        .lat    (cap_lat),
        .expire (expire),
        .busy   (cnt_busy)
    );

    always_comb begin
        req_lat     = hs_clamp_lat(lat_cfg, LAT_W'(MIN_LAT), LAT_W'(MAX_LAT));
        in_flight   = state_q inside {WAIT, ACK, DONE};
        take_slot   = (state_q == DONE) && slot_full_q;
        // A req in DONE with an empty slot bypasses the slot and starts immediately.
        cap         = take_slot || (req && (state_q == READY || (state_q == DONE && !slot_full_q)));
        cap_lat     = take_slot ? slot_lat_q : req_lat;
        cap_data    = take_slot ? slot_data_q : req_data;
        store       = req && !slot_full_q && (state_q == WAIT || state_q == ACK);
        state_d     = state_q;
        case (state_q)
            IDLE:    state_d = start ? READY : IDLE;
            WAIT:    state_d = (expire || !cnt_busy) ? ACK : WAIT;
            ACK:     state_d = DONE;
            DONE:    state_d = READY;
            default: state_d = state_q;
        endcase
        if (cap) state_d = (cap_lat == LAT_W'(1)) ? ACK : WAIT;
        cur_data_d  = cap ? cap_data : cur_data_q;
        slot_full_d = store || (slot_full_q && !take_slot);
        slot_data_d = store ? req_data : slot_data_q;
        slot_lat_d  = store ? req_lat : slot_lat_q;
        ovf_d       = ovf_q || (req && in_flight && slot_full_q);
        ack_d       = (state_d == ACK);
        done_d      = (state_d == DONE);
        busy_d      = state_d inside {WAIT, ACK, DONE};
        data_d      = ack_d ? cur_data_d : data_q;
        txn_cnt_d   = txn_cnt_q + 16'(done_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_data_q  <= '0;
            slot_data_q <= '0;
            slot_lat_q  <= '0;
            slot_full_q <= 1'b0;
            data_q      <= '0;
            ack_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
            txn_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cur_data_q  <= cur_data_d;
            slot_data_q <= slot_data_d;
            slot_lat_q  <= slot_lat_d;
            slot_full_q <= slot_full_d;
            data_q      <= data_d;
            ack_q       <= ack_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
            txn_cnt_q   <= txn_cnt_d;
        end
    end

    assign ack     = ack_q;
    assign done    = done_q;
    assign data    = data_q;
    assign busy    = busy_q;
    assign ovf     = ovf_q;
    assign txn_cnt = txn_cnt_q;
endmodule

// File: tb/tb_hs_responder.sv
// tb_hs_responder: directed handshake scenarios; iteration j samples outputs just after edge j.
module tb_hs_responder;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, req = 1'b0;
    logic [2:0]  lat_cfg = '0;
    logic [7:0]  req_data = '0;
    logic        ack, done, busy, ovf;
    logic [7:0]  data;
    logic [15:0] txn_cnt;
    int          checks = 0, errors = 0;

    hs_responder #(.MIN_LAT(1), .MAX_LAT(5), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .req(req), .lat_cfg(lat_cfg),
        .req_data(req_data), .ack(ack), .done(done), .data(data), .busy(busy),
        .ovf(ovf), .txn_cnt(txn_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [2:0] l, input logic [7:0] d);
        req = r;
        lat_cfg = l;
        req_data = d;
        step();
    endtask

    task automatic reset_arm(input logic do_arm);
        rst_n = 1'b0; start = 1'b0; req = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        if (do_arm) begin
            start = 1'b1;
            step();
            start = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; req = 1'b1;
        step();
        step();
        checks++;
        if ({ack, done, busy, ovf} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags ack/done/busy/ovf=%b expected 0000", {ack, done, busy, ovf});
        end
        checks++;
        if ({data, txn_cnt} !== 24'h0) begin
            errors++;
            $display("FAIL reset_values data=%h txn_cnt=%h expected 0", data, txn_cnt);
        end
    endtask

    task automatic test_basic();
        logic [7:0] em = 8'b0000_0100, dm = 8'b0000_1000;
        reset_arm(1'b1);
        for (int j = 0; j < 8; j++) begin
            drive(j == 0, 3'd3, 8'hA5);
            checks++;
            if ({ack, done} !== {em[j], dm[j]}) begin
                errors++;
                $display("FAIL basic_hs j=%0d ack/done=%b%b expected %b%b", j, ack, done, em[j], dm[j]);
            end
            if (j == 2) begin
                checks++;
                if (data !== 8'hA5) begin
                    errors++;
                    $display("FAIL basic_data data=%h expected a5", data);
                end
            end
        end
        checks++;
        if (txn_cnt !== 16'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_end txn_cnt=%0d busy=%b expected 1 0", txn_cnt, busy);
        end
    endtask

    task automatic test_lat_clamp();
        logic [11:0] em = 12'b0000_1000_0001, dm = 12'b0001_0000_0010;
        reset_arm(1'b1);
        for (int j = 0; j < 12; j++) begin
            drive(j == 0 || j == 3, (j == 0) ? 3'd0 : 3'd7, (j == 0) ? 8'h11 : 8'h22);
            checks++;
            if ({ack, done} !== {em[j], dm[j]}) begin
                errors++;
                $display("FAIL clamp_hs j=%0d ack/done=%b%b expected %b%b", j, ack, done, em[j], dm[j]);
            end
            if (j == 0 || j == 7) begin
                checks++;
                if (data !== ((j == 0) ? 8'h11 : 8'h22)) begin
                    errors++;
                    $display("FAIL clamp_data j=%0d data=%h", j, data);
                end
            end
        end
    endtask

    task automatic test_idle();
        reset_arm(1'b0);
        for (int j = 0; j < 12; j++) begin
            start = (j == 6);
            drive(j < 7, 3'd2, 8'h33);
            checks++;
            if ({ack, done, busy, ovf} !== 4'b0) begin
                errors++;
                $display("FAIL idle_ignore j=%0d ack/done/busy/ovf=%b expected 0000", j, {ack, done, busy, ovf});
            end
        end
        start = 1'b0;
        drive(1'b1, 3'd1, 8'h44);
        checks++;
        if (ack !== 1'b1 || data !== 8'h44) begin
            errors++;
            $display("FAIL idle_armed ack=%b data=%h expected 1 44", ack, data);
        end
        drive(1'b0, 3'd1, 8'h00);
    endtask

    task automatic test_back_to_back();
        logic [7:0] em = 8'b0000_1010, dm = 8'b0001_0100;
        reset_arm(1'b1);
        for (int j = 0; j < 8; j++) begin
            drive(j < 2, (j == 0) ? 3'd2 : 3'd1, (j == 0) ? 8'hB1 : 8'hB2);
            checks++;
            if ({ack, done} !== {em[j], dm[j]}) begin
                errors++;
                $display("FAIL b2b_hs j=%0d ack/done=%b%b expected %b%b", j, ack, done, em[j], dm[j]);
            end
            if (j == 1 || j == 3) begin
                checks++;
                if (data !== ((j == 1) ? 8'hB1 : 8'hB2)) begin
                    errors++;
                    $display("FAIL b2b_data j=%0d data=%h", j, data);
                end
            end
        end
        checks++;
        if (txn_cnt !== 16'd2 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end txn_cnt=%0d ovf=%b expected 2 0", txn_cnt, ovf);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] em = 16'h0410, dm = 16'h0820;
        int nack = 0;
        reset_arm(1'b1);
        for (int j = 0; j < 16; j++) begin
            drive(j < 3, 3'd5, 8'(8'hC0 + j));
            nack += int'(ack);
            checks++;
            if ({ack, done, ovf} !== {em[j], dm[j], j >= 2}) begin
                errors++;
                $display("FAIL ovf_hs j=%0d ack/done/ovf=%b%b%b expected %b%b%b",
                         j, ack, done, ovf, em[j], dm[j], j >= 2);
            end
            if (j == 10) begin
                checks++;
                if (data !== 8'hC1) begin
                    errors++;
                    $display("FAIL ovf_data data=%h expected c1", data);
                end
            end
        end
        checks++;
        if (nack !== 2) begin
            errors++;
            $display("FAIL ovf_ack_count acks=%0d expected 2", nack);
        end
    endtask

    task automatic test_reset_mid();
        reset_arm(1'b1);
        for (int j = 0; j < 8; j++) begin
            rst_n = (j != 2);
            drive(j == 0, 3'd4, 8'hD4);
            checks++;
            if ({ack, done} !== 2'b00) begin
                errors++;
                $display("FAIL rstmid_hs j=%0d ack/done=%b%b expected 00", j, ack, done);
            end
            if (j == 1 || j == 2) begin
                checks++;
                if (busy !== (j == 1)) begin
                    errors++;
                    $display("FAIL rstmid_busy j=%0d busy=%b", j, busy);
                end
            end
        end
        rst_n = 1'b1;
        checks++;
        if ({busy, ovf, data, txn_cnt} !== 26'h0) begin
            errors++;
            $display("FAIL rstmid_out busy=%b ovf=%b data=%h txn_cnt=%h expected 0", busy, ovf, data, txn_cnt);
        end
    endtask

    task automatic test_wrap();
        reset_arm(1'b1);
        force dut.txn_cnt_q = 16'hFFFF;
        step();
        release dut.txn_cnt_q;
        checks++;
        if (txn_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_preload txn_cnt=%h expected ffff", txn_cnt);
        end
        drive(1'b1, 3'd1, 8'hE7);
        drive(1'b0, 3'd1, 8'h00);
        checks++;
        if (done !== 1'b1 || txn_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL wrap done=%b txn_cnt=%h expected 1 0000", done, txn_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lat_clamp();
        test_idle();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
